// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

   localparam int DIV_DEFAULT = 8;
   localparam int DIV_HALT    = 0;

   // What a channel does on the coming edge, in priority order below reset.
   typedef enum logic [1:0] {
      CH_SYNC,
      CH_HALT,
      CH_HOLD,
      CH_RUN
   } ch_mode_e;

   // Divided clock is high once the next count reaches N>>1; odd N gets the longer high half.
   function automatic logic duty_hi(input logic [31:0] cnt_nx, input logic [31:0] n);
      return cnt_nx >= (n >> 1);
   endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control and strobe bundle between a controller and the divider bank.
interface clk_div_multi_if #(
   parameter int NUM_CH = 2,
   parameter int WIDTH  = 8
);
   logic [NUM_CH-1:0]       en;
   logic                    sync;
   logic [NUM_CH-1:0]       div_we;
   logic [NUM_CH*WIDTH-1:0] div_in;
   logic [NUM_CH-1:0]       div_pend;
   logic [NUM_CH-1:0]       clk_o;
   logic [NUM_CH-1:0]       tick_o;

   modport master (
      output en, sync, div_we, div_in,
      input  div_pend, clk_o, tick_o
   );

   modport slave (
      input  en, sync, div_we, div_in,
      output div_pend, clk_o, tick_o
   );
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow divisor pair and registered level/tick outputs.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int RST_DIV = DIV_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             we,
   input  logic [WIDTH-1:0] din,
   output logic             pend,
   output logic             clk_o,
   output logic             tick_o
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] cnt_nx;
   logic             at_end;
   logic             wrap;
   ch_mode_e         mode;

   assign at_end = (cnt == n - WIDTH'(1));
   assign cnt_nx = at_end ? '0 : cnt + WIDTH'(1);
   assign wrap   = (mode == CH_RUN) && at_end;

   always_comb begin
      mode = CH_RUN;
      if (sync)
         mode = CH_SYNC;
      else if (n == WIDTH'(DIV_HALT))
         mode = CH_HALT;
      else if (!en)
         mode = CH_HOLD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         n      <= WIDTH'(RST_DIV);
         s      <= WIDTH'(RST_DIV);
         pend   <= 1'b0;
         clk_o  <= 1'b0;
         tick_o <= 1'b0;
      end else begin
         case (mode)
            CH_SYNC: begin
               cnt    <= '0;
               clk_o  <= 1'b0;
               tick_o <= 1'b0;
               pend   <= 1'b0;
               if (we) begin
                  n <= din;
                  s <= din;
               end else if (pend) begin
                  n <= s;
               end
            end
            CH_HALT: begin
               // A halted channel has no period to finish, so a pending divisor lands next edge.
               cnt    <= '0;
               clk_o  <= 1'b0;
               tick_o <= 1'b0;
               if (we) begin
                  s    <= din;
                  pend <= 1'b1;
               end else if (pend) begin
                  n    <= s;
                  pend <= 1'b0;
               end
            end
            default: begin
               // Divisor changes only at the wrap so the running period is never cut short.
               if (wrap && we) begin
                  n    <= din;
                  s    <= din;
                  pend <= 1'b0;
               end else if (wrap && pend) begin
                  n    <= s;
                  pend <= 1'b0;
               end else if (we) begin
                  s    <= din;
                  pend <= 1'b1;
               end

               if (mode == CH_RUN) begin
                  cnt    <= cnt_nx;
                  tick_o <= at_end;
                  clk_o  <= duty_hi(32'(cnt_nx), 32'(n));
               end else begin
                  tick_o <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/clk_div_multi.sv
// Bank of independent programmable clock dividers sharing one phase-align strobe.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int WIDTH   = 8,
   parameter int RST_DIV = DIV_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   clk_div_multi_if.slave        bus
);

   logic [NUM_CH-1:0]       en;
   logic [NUM_CH-1:0]       we;
   logic [NUM_CH*WIDTH-1:0] din;
   logic                    sync;
   logic [NUM_CH-1:0]       pend;
   logic [NUM_CH-1:0]       clk_lvl;
   logic [NUM_CH-1:0]       tick;

   assign en   = bus.en;
   assign we   = bus.div_we;
   assign din  = bus.div_in;
   assign sync = bus.sync;

   assign bus.div_pend = pend;
   assign bus.clk_o    = clk_lvl;
   assign bus.tick_o   = tick;

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         clk_div_ch #(
            .WIDTH   (WIDTH),
            .RST_DIV (RST_DIV)
         ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en[i]),
            .sync   (sync),
            .we     (we[i]),
            .din    (din[i*WIDTH +: WIDTH]),
            .pend   (pend[i]),
            .clk_o  (clk_lvl[i]),
            .tick_o (tick[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: stimulus queues per-edge expectations, a monitor retires them.
module tb_clk_div_multi;

   localparam int NCH = 2;
   localparam int W   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   clk_div_multi_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();

   clk_div_multi #(.NUM_CH(NCH), .WIDTH(W), .RST_DIV(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         at;
      int         ch;
      bit         kind;  // 0: {clk_o,tick_o}, 1: div_pend
      logic [1:0] v;
      int         ph;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;
   int   b, r;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic cmpv(input int ph, input string nm, input int ch,
                       input logic [1:0] act, input logic [1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL ph%0d %s ch%0d edge%0d got %b want %b", ph, nm, ch, edge_n, act, want);
      end
   endtask

   task automatic push(input int at, input int ch, input bit kind, input logic [1:0] v, input int ph);
      exp_t e;
      e.at = at; e.ch = ch; e.kind = kind; e.v = v; e.ph = ph;
      sb.push_back(e);
   endtask

   // pat[j] is clk_o after edge start+j+1; tick expected on the last position when tk is set
   task automatic exp_pat(input int start, input int ch, input string pat, input bit tk, input int ph);
      for (int j = 0; j < pat.len(); j++)
         push(start + j + 1, ch, 1'b0,
              {pat.getc(j) == 8'h31, tk && (j == pat.len() - 1)}, ph);
   endtask

   task automatic exp_pend(input int from, input int to, input int ch, input logic v, input int ph);
      for (int e = from; e <= to; e++) push(e, ch, 1'b1, {1'b0, v}, ph);
   endtask

   task automatic exp_lvl(input int from, input int to, input int ch, input logic [1:0] v, input int ph);
      for (int e = from; e <= to; e++) push(e, ch, 1'b0, v, ph);
   endtask

   task automatic goto(input int e);
      while (edge_n < e) @(negedge clk);
   endtask

   task automatic wr(input int ch, input logic [W-1:0] v);
      bus.div_we[ch]        = 1'b1;
      bus.div_in[ch*W +: W] = v;
      @(negedge clk);
      bus.div_we = '0;
   endtask

   always @(negedge clk) begin : mon
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].at == edge_n) begin
            if (sb[i].kind)
               cmpv(sb[i].ph, "pend", sb[i].ch, {1'b0, bus.div_pend[sb[i].ch]}, sb[i].v);
            else
               cmpv(sb[i].ph, "clk/tick", sb[i].ch,
                    {bus.clk_o[sb[i].ch], bus.tick_o[sb[i].ch]}, sb[i].v);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired at edge%0d", edge_n);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.en     = '0;
      bus.sync   = 1'b0;
      bus.div_we = '0;
      bus.div_in = '0;
      repeat (2) @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         push(edge_n + 1, c, 1'b0, 2'b00, 0);
         push(edge_n + 1, c, 1'b1, 2'b00, 0);
      end
      @(negedge clk);

      // reset release with default divisor 8
      rst    = 1'b0;
      bus.en = '1;
      b      = edge_n;
      for (int c = 0; c < NCH; c++) begin
         exp_pat(b,      c, "00011110", 1'b1, 1);
         exp_pat(b + 8,  c, "00011110", 1'b1, 1);
         exp_pat(b + 16, c, "00011110", 1'b1, 1);
      end
      exp_pat(b + 24, 1, "00011110", 1'b1, 2);
      exp_pend(b + 1, b + 32, 1, 1'b0, 2);
      // write 5 at cnt=2 on ch0
      exp_pend(b + 1,  b + 18, 0, 1'b0, 2);
      exp_pend(b + 19, b + 23, 0, 1'b1, 2);
      exp_pend(b + 24, b + 24, 0, 1'b0, 2);
      exp_pat(b + 24, 0, "01110", 1'b1, 2);
      exp_pat(b + 29, 0, "01110", 1'b1, 2);
      // write 3 on the wrap edge
      exp_pend(b + 33, b + 35, 0, 1'b0, 3);
      exp_pat(b + 34, 0, "110", 1'b1, 3);
      exp_pat(b + 37, 0, "110", 1'b1, 3);
      // halt then restart with 4
      exp_pat(b + 40, 0, "110", 1'b1, 4);
      exp_pend(b + 41, b + 42, 0, 1'b1, 4);
      exp_pend(b + 43, b + 50, 0, 1'b0, 4);
      exp_lvl(b + 44, b + 52, 0, 2'b00, 4);
      exp_pend(b + 51, b + 51, 0, 1'b1, 4);
      exp_pend(b + 52, b + 52, 0, 1'b0, 4);
      exp_pat(b + 52, 0, "0110", 1'b1, 4);
      exp_pat(b + 56, 0, "0110", 1'b1, 4);
      // divisors 6 / 9 at different phases, then sync
      exp_pend(b + 65, b + 67, 0, 1'b1, 5);
      exp_pend(b + 68, b + 68, 0, 1'b0, 5);
      exp_pend(b + 65, b + 71, 1, 1'b1, 5);
      exp_pend(b + 72, b + 72, 1, 1'b0, 5);
      exp_lvl(b + 79, b + 79, 0, 2'b00, 5);
      exp_lvl(b + 79, b + 79, 1, 2'b00, 5);
      exp_pat(b + 79, 0, "001110",    1'b1, 5);
      exp_pat(b + 79, 1, "000111110", 1'b1, 5);

      goto(b + 18); wr(0, 8'd5);
      goto(b + 33); wr(0, 8'd3);
      goto(b + 40); wr(0, 8'd0);
      goto(b + 50); wr(0, 8'd4);
      goto(b + 64);
      bus.div_we = 2'b11;
      bus.div_in = {8'd9, 8'd6};
      @(negedge clk);
      bus.div_we = '0;
      goto(b + 78);
      bus.sync = 1'b1;
      @(negedge clk);
      bus.sync = 1'b0;

      // async reset while ch0 is high with a divisor pending
      goto(b + 89);
      push(b + 90, 0, 1'b0, 2'b10, 6);
      push(b + 90, 0, 1'b1, 2'b01, 6);
      wr(0, 8'd2);
      #2 rst = 1'b1;
      #1;
      for (int c = 0; c < NCH; c++) begin
         cmpv(6, "async rst clk/tick", c, {bus.clk_o[c], bus.tick_o[c]}, 2'b00);
         cmpv(6, "async rst pend", c, {1'b0, bus.div_pend[c]}, 2'b00);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      r   = edge_n;
      for (int c = 0; c < NCH; c++) begin
         exp_pat(r, c, "00011110", 1'b1, 7);
         exp_pend(r + 1, r + 2, c, 1'b0, 7);
      end
      exp_pat(r + 8,  1, "00011110", 1'b1, 7);
      exp_pat(r + 16, 1, "00011110", 1'b1, 7);
      // ch0 paused for 5 edges while clk_o is high
      exp_pat(r + 8, 0, "00011", 1'b0, 7);
      exp_lvl(r + 14, r + 20, 0, 2'b10, 7);
      exp_lvl(r + 21, r + 21, 0, 2'b01, 7);
      exp_pat(r + 21, 0, "00011110", 1'b1, 7);

      goto(r + 13); bus.en[0] = 1'b0;
      goto(r + 18); bus.en[0] = 1'b1;
      goto(r + 32);
      @(negedge clk);

      while (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL expired ph%0d ch%0d due edge%0d never checked", sb[0].ph, sb[0].ch, sb[0].at);
         void'(sb.pop_front());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider that generates per-channel divided clock levels and single-cycle clock-enable ticks from the system clock. Each channel's divisor is programmable at run time and takes effect glitch-free at the channel's next wrap. A global sync strobe phase-aligns all channels. It sits beside the processor/VGA logic and supplies fixed- and variable-rate strobes, for example pixel-rate, UART baud and timer ticks.

## Interface
Parameters:
- NUM_CH, 2, number of independent channels.
- WIDTH, 8, divisor and counter width in bits.
- RST_DIV, 8, divisor loaded into every channel at reset.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  NUM_CH  per-channel count enable.
- sync  in  1  single-cycle strobe that restarts all channels in phase.
- div_we  in  NUM_CH  per-channel divisor write strobe.
- div_in  in  NUM_CH*WIDTH  new divisors; channel i uses bits [i*WIDTH +: WIDTH].
- div_pend  out  NUM_CH  a written divisor is waiting to be applied.
- clk_o  out  NUM_CH  registered divided clock level.
- tick_o  out  NUM_CH  registered one-cycle pulse, once per divided period.

## Operation
- Per-channel state:
  - cnt[WIDTH], the counter.
  - N, the active divisor.
  - S, the shadow divisor.
  - pend, the pending flag.
  - clk_o and tick_o flops.
- Reset values:
  - cnt=0, N=S=RST_DIV, pend=0.
  - clk_o=0, tick_o=0.
- Counting, when en[i]=1 and N≥1:
  - cnt_nx = (cnt==N-1) ? 0 : cnt+1.
  - cnt<=cnt_nx.
  - tick_o<=(cnt==N-1).
  - clk_o<=(cnt_nx ≥ N>>1).
- Duty cycle:
  - Even N gives 50% duty.
  - Odd N is high for ceil(N/2) cycles.
- N=1: tick_o is high every cycle and clk_o is constantly 1.
- N=0 means the channel is halted: cnt held at 0, clk_o<=0, tick_o<=0.
- en[i]=0: cnt and clk_o hold, and tick_o<=0.
- Divisor write:
  - div_we[i] captures S<=div_in slice and sets pend.
  - S is copied to N and pend cleared at the wrap edge, i.e. the edge where cnt==N-1 with en=1.
  - If N==0, the copy happens immediately on the next edge.
  - The counter never sees a divisor change mid-period, so there are no runt pulses.
- Write on the wrap edge: the written value bypasses S and becomes N on that same edge; pend stays 0.
- Back-to-back writes before a wrap: the last write wins.
- sync=1, on all channels regardless of en:
  - cnt<=0, clk_o<=0, tick_o<=0.
  - N<=S if pend (or the div_in value if div_we is also set); pend<=0.
- Priority: rst > sync > div_we/wrap > count.
- Reset mid-operation aborts immediately (asynchronous), and all channels return to RST_DIV.

## Timing
- All outputs are flops, with no combinational path from any input to any output.
- First pulses after reset release with N=8 and en held high:
  - clk_o rises on the 4th rising edge and falls on the 8th.
  - tick_o is high for the single cycle after the 8th edge.
  - The period is then 8 clocks.
- Latency:
  - en, sync and div_we act on the same edge they are sampled.
  - A new divisor's first full period begins on the edge after the wrap.
- div_pend rises on the edge after div_we and falls on the applying edge.
- Width rules:
  - Maximum divisor is 2^WIDTH-1.
  - cnt never exceeds N-1, so the counter cannot overflow.

## Structure
- Shared package clk_div_pkg holds:
  - the default divisor constant (DIV_DEFAULT=8);
  - the halt encoding (DIV_HALT=0);
  - the compare helper for the duty threshold (N>>1).
- Sub-module clk_div_ch implements one channel, with ports clk, rst, en, sync, we, din, pend, clk_o, tick_o.
- The top instantiates clk_div_ch NUM_CH times via generate and slices div_in.

## Test plan
- Reset release, defaults, en=all 1:
  - both channels: clk_o low for edges 1-3, high for edges 4-7;
  - tick_o high after edge 8 and then every 8 cycles.
- Write 5 to channel 0 at cnt=2:
  - div_pend=1 until the wrap, then 0;
  - the following period is 5 cycles with clk_o high for 3;
  - channel 1 is unaffected.
- div_we with value 3 on the exact wrap edge: no pend, and the next period is 3.
- Write 0 (halt):
  - after the wrap, clk_o and tick_o stay 0;
  - a later write of 4 applies on the next edge, and ticks resume every 4 cycles.
- Channels at divisors 6 and 9 with arbitrary phase, then a sync pulse: both restart with cnt=0, and their first tick_o occur 6 and 9 edges after sync.
- Assert rst mid-period with a divisor pending:
  - outputs go 0 immediately, and pend clears;
  - after release, the divisor is 8 again, not the pending value.
- en[0]=0 for 5 cycles mid-period: clk_o holds, no ticks, and the period resumes exactly where it stopped.
